// File: rtl/lp_pkg.sv
// rtl/lp_pkg.sv - shared types and defaults for the serial frame deserializer
package lp_pkg;

  localparam int FRAME_BITS_DEF = 256;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    HUNT,
    RUN,
    SKIP
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } byte_tag_t;

endpackage

// File: rtl/lp_sync_fifo.sv
// rtl/lp_sync_fifo.sv - first-word-fall-through synchronous FIFO
module lp_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit tells a full buffer apart from an empty one.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (do_rd) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/lp_frame_deser.sv
// rtl/lp_frame_deser.sv - rebuilds wc-delimited serial frames into a tagged byte stream
module lp_frame_deser
  import lp_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wc,
  input  logic       bitclock,
  input  logic       locked,
  input  logic       sdata,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_eof,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       in_sync,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  state_t          state;
  logic            wc_d;
  logic            bc_d;
  logic [CW-1:0]   bitcnt;
  logic [7:0]      shreg;
  logic            sof_pend;

  logic            wc_rise;
  logic            bc_rise;
  logic            restart;
  logic [CW-1:0]   cnt_eff;
  logic [CW-1:0]   cnt_next;
  logic            sof_eff;
  logic            take_bit;
  logic            push;
  byte_tag_t       push_tag;
  logic            fifo_full;
  logic            fifo_empty;
  logic [9:0]      fifo_rd;
  byte_tag_t       rd_tag;

  assign wc_rise = !wc_d && wc;
  assign bc_rise = !bc_d && bitclock;

  // A frame boundary is applied before any coincident bit, so that bit
  // becomes bit 0 of the new frame.
  always_comb begin
    restart       = wc_rise && (state == RUN || state == SKIP);
    cnt_eff       = restart ? '0 : bitcnt;
    sof_eff       = restart || sof_pend;
    cnt_next      = cnt_eff + CW'(1);
    take_bit      = bc_rise && locked && (state == RUN || restart)
                    && (cnt_eff < CW'(FRAME_BITS));
    push          = take_bit && (cnt_next[2:0] == 3'd0);
    push_tag.data = {shreg[6:0], sdata};
    push_tag.sof  = sof_eff;
    push_tag.eof  = (cnt_next == CW'(FRAME_BITS));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= HUNT;
      wc_d      <= 1'b0;
      bc_d      <= 1'b0;
      bitcnt    <= '0;
      shreg     <= '0;
      sof_pend  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wc_d      <= wc;
      bc_d      <= bitclock;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      case (state)
        HUNT: begin
          if (wc_rise && locked) begin
            state    <= RUN;
            bitcnt   <= '0;
            sof_pend <= 1'b1;
          end
        end
        RUN, SKIP: begin
          if (!locked) begin
            state  <= HUNT;
            bitcnt <= '0;
          end else begin
            if (state == RUN && wc_rise && bitcnt != CW'(FRAME_BITS)) begin
              frame_err <= 1'b1;
            end
            if (restart) begin
              state <= RUN;
            end
            bitcnt   <= cnt_eff;
            sof_pend <= sof_eff;
            if (take_bit) begin
              shreg  <= {shreg[6:0], sdata};
              bitcnt <= cnt_next;
              if (push) begin
                sof_pend <= 1'b0;
                if (fifo_full) begin
                  overflow <= 1'b1;
                  state    <= SKIP;
                end
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  lp_sync_fifo #(
    .WIDTH($bits(byte_tag_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_tag),
    .full    (fifo_full),
    .rd_en   (m_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  // Stale storage is masked so the byte outputs read zero while empty.
  assign rd_tag  = byte_tag_t'(fifo_rd);
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? 8'h00 : rd_tag.data;
  assign m_sof   = !fifo_empty && rd_tag.sof;
  assign m_eof   = !fifo_empty && rd_tag.eof;
  assign in_sync = (state == RUN);

endmodule

// File: tb/tb_lp_frame_deser.sv
// tb/tb_lp_frame_deser.sv - randomized self-checking bench for lp_frame_deser
module tb_lp_frame_deser;

  localparam int FB = 256;
  localparam int FD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wc = 1'b0;
  logic       bitclock = 1'b0;
  logic       locked = 1'b0;
  logic       sdata = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eof;
  logic       m_valid;
  logic       in_sync;
  logic       frame_err;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] exp_q[$];
  logic       frame_bits[$];
  int         mode = 0;
  int         fe_exp = 0;
  int         ov_exp = 0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  bit         rand_ready = 1'b0;

  lp_frame_deser #(
    .FRAME_BITS(FB),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wc        (wc),
    .bitclock  (bitclock),
    .locked    (locked),
    .sdata     (sdata),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eof     (m_eof),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .in_sync   (in_sync),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: a frame is the list of bits received since its boundary;
  // every eighth bit forms a byte, first byte tagged sof, bit FB tagged eof.
  task automatic model_bit(input logic b);
    int n;
    logic [7:0] v;
    if (mode == 1 && frame_bits.size() < FB) begin
      frame_bits.push_back(b);
      n = frame_bits.size();
      if (n % 8 == 0) begin
        v = 8'h00;
        for (int i = n - 8; i < n; i++) v = {v[6:0], frame_bits[i]};
        if (exp_q.size() >= FD) begin
          ov_exp++;
          mode = 2;
        end else begin
          exp_q.push_back({v, (n == 8), (n == FB)});
        end
      end
    end
  endtask

  task automatic model_wc();
    if (locked) begin
      if (mode == 1 && frame_bits.size() != FB) fe_exp++;
      mode = 1;
      frame_bits.delete();
    end
  endtask

  task automatic send_bit(input logic b);
    model_bit(b);
    sdata = b;
    bitclock = 1'b1;
    tick();
    tick();
    bitclock = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_wc();
    model_wc();
    wc = 1'b1;
    tick();
    tick();
    wc = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, (exp_q.size() == 0 && !m_valid), 1);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (frame_err === 1'b1) fe_seen++;
      if (overflow === 1'b1) ov_seen++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        chk("byte_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("byte_tag", {m_data, m_sof, m_eof}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, hunt, first boundary
    for (int i = 0; i < 5; i++) tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_bus", {m_data, m_sof, m_eof}, 0);
    chk("rst_status", {in_sync, frame_err, overflow}, 0);
    reset = 1'b1;
    locked = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
    chk("hunt_valid", m_valid, 0);
    chk("hunt_sync", in_sync, 0);
    model_wc();
    wc = 1'b1;
    tick();
    chk("sync_after_wc", in_sync, 1);
    tick();
    wc = 1'b0;
    tick();
    tick();

    // 2: counting frame
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    send_wc();
    drain("drain_count");
    chk("count_ferr", fe_seen, 0);

    // 3: short frame then clean frame
    for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)));
    send_wc();
    drain("drain_short");
    chk("short_ferr", fe_seen, 1);
    for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    send_wc();
    drain("drain_after_short");
    chk("clean_ferr", fe_seen, fe_exp);

    // random frame lengths, including long frames
    for (int f = 0; f < 6; f++) begin
      int len;
      len = (f == 0) ? FB : $urandom_range(FB - 40, FB + 24);
      for (int i = 0; i < len; i++) send_bit(1'($urandom_range(0, 1)));
      send_wc();
    end
    drain("drain_random");
    chk("random_ferr", fe_seen, fe_exp);

    // 4: stalled consumer overflows once
    rand_ready = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    chk("ovf_count", ov_seen, 1);
    chk("ovf_model", ov_seen, ov_exp);
    chk("ovf_held", exp_q.size(), FD);
    chk("ovf_valid", m_valid, 1);
    chk("skip_sync", in_sync, 0);
    rand_ready = 1'b1;
    send_wc();
    chk("skip_to_run", in_sync, 1);
    for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    send_wc();
    drain("drain_ovf");
    chk("ovf_ferr", fe_seen, fe_exp);

    // 5: lock loss mid-frame
    for (int i = 0; i < 50; i++) send_bit(1'($urandom_range(0, 1)));
    locked = 1'b0;
    mode = 0;
    frame_bits.delete();
    tick();
    chk("unlock_sync", in_sync, 0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
    drain("drain_unlock");
    locked = 1'b1;
    tick();
    send_wc();
    for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    send_wc();
    drain("drain_relock");
    chk("relock_ferr", fe_seen, fe_exp);

    // 6: reset while bytes are pending
    rand_ready = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    chk("pre_rst_valid", m_valid, 1);
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_bus", {m_data, m_sof, m_eof}, 0);
    chk("mid_rst_status", {in_sync, frame_err, overflow}, 0);
    exp_q.delete();
    frame_bits.delete();
    mode = 0;
    tick();
    reset = 1'b1;
    m_ready = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_sync", in_sync, 0);
    rand_ready = 1'b1;
    send_wc();
    for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    send_wc();
    drain("drain_post_rst");
    chk("final_ferr", fe_seen, fe_exp);
    chk("final_ovf", ov_seen, ov_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
